// File: rtl/phys_reg_read.sv
// Register-read stage: 2^PREG_BITS physical register file with two writeback ports feeding a registered execute packet.
// Define PHYS_REG_READ_BYPASS_EN to forward same-cycle writeback data into the operands.
module phys_reg_read #(
   parameter int DATA_WIDTH = 32,
   parameter int PREG_BITS  = 6,
   parameter int ISS_WIDTH  = 137
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FREEZE,
   input  logic                  FLUSH_IN,
   input  logic                  ISS_valid_IN,
   input  logic                  ISS_mem_IN,
   input  logic [ISS_WIDTH-1:0]  ISS_data_IN,
   input  logic                  WB0_valid_IN,
   input  logic [PREG_BITS-1:0]  WB0_reg_IN,
   input  logic [DATA_WIDTH-1:0] WB0_data_IN,
   input  logic                  WB1_valid_IN,
   input  logic [PREG_BITS-1:0]  WB1_reg_IN,
   input  logic [DATA_WIDTH-1:0] WB1_data_IN,
   output logic                  EX_valid_OUT,
   output logic                  EX_mem_OUT,
   output logic [DATA_WIDTH-1:0] EX_opA_OUT,
   output logic [DATA_WIDTH-1:0] EX_opB_OUT,
   output logic [DATA_WIDTH-1:0] EX_storeData_OUT,
   output logic [PREG_BITS-1:0]  EX_dest_OUT,
   output logic                  EX_needDest_OUT,
   output logic [5:0]            EX_aluCtl_OUT,
   output logic [5:0]            EX_ctl_OUT,
   output logic [5:0]            EX_rob_OUT,
   output logic [31:0]           EX_pc_OUT,
   output logic [31:0]           EX_instr_OUT
);

   localparam int NUM_REGS = 1 << PREG_BITS;

   logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
   logic [31:0]           rd_count;

   logic [31:0]           issPc;
   logic [5:0]            issCtl;
   logic                  issImmSrc;
   logic                  issNeedDest;
   logic [PREG_BITS-1:0]  issDest;
   logic [PREG_BITS-1:0]  issSrc2;
   logic [PREG_BITS-1:0]  issSrc1;
   logic [31:0]           issImm;
   logic [5:0]            issAluCtl;
   logic [5:0]            issRob;
   logic [31:0]           issInstr;

   assign issPc       = ISS_data_IN[136:105];
   assign issCtl      = ISS_data_IN[103:98];
   assign issImmSrc   = ISS_data_IN[97];
   assign issNeedDest = ISS_data_IN[96];
   assign issDest     = ISS_data_IN[90 +: PREG_BITS];
   assign issSrc2     = ISS_data_IN[83 +: PREG_BITS];
   assign issSrc1     = ISS_data_IN[76 +: PREG_BITS];
   assign issImm      = ISS_data_IN[75:44];
   assign issAluCtl   = ISS_data_IN[43:38];
   assign issRob      = ISS_data_IN[37:32];
   assign issInstr    = ISS_data_IN[31:0];

   logic [DATA_WIDTH-1:0] src1Val;
   logic [DATA_WIDTH-1:0] src2Val;
   logic                  accept;

   assign accept = RESET && !FLUSH_IN && !FREEZE && ISS_valid_IN;

`ifdef PHYS_REG_READ_BYPASS_EN
   // WB0 is checked last so it takes priority when both ports hit the same source.
   always_comb begin
      src1Val = regFile[issSrc1];
      src2Val = regFile[issSrc2];
      if (WB1_valid_IN && (WB1_reg_IN == issSrc1)) src1Val = WB1_data_IN;
      if (WB0_valid_IN && (WB0_reg_IN == issSrc1)) src1Val = WB0_data_IN;
      if (WB1_valid_IN && (WB1_reg_IN == issSrc2)) src2Val = WB1_data_IN;
      if (WB0_valid_IN && (WB0_reg_IN == issSrc2)) src2Val = WB0_data_IN;
   end
`else
   assign src1Val = regFile[issSrc1];
   assign src2Val = regFile[issSrc2];
`endif

   // Writebacks ignore FREEZE; WB0 is written last so it wins a same-register conflict.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regFile[i] <= '0;
         end
      end else begin
         if (WB1_valid_IN) regFile[WB1_reg_IN] <= WB1_data_IN;
         if (WB0_valid_IN) regFile[WB0_reg_IN] <= WB0_data_IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         EX_valid_OUT     <= 1'b0;
         EX_mem_OUT       <= 1'b0;
         EX_opA_OUT       <= '0;
         EX_opB_OUT       <= '0;
         EX_storeData_OUT <= '0;
         EX_dest_OUT      <= '0;
         EX_needDest_OUT  <= 1'b0;
         EX_aluCtl_OUT    <= '0;
         EX_ctl_OUT       <= '0;
         EX_rob_OUT       <= '0;
         EX_pc_OUT        <= '0;
         EX_instr_OUT     <= '0;
      end else if (FLUSH_IN) begin
         EX_valid_OUT <= 1'b0;
      end else if (!FREEZE) begin
         // Payload fields keep their last values when no packet is issued.
         EX_valid_OUT <= ISS_valid_IN;
         if (ISS_valid_IN) begin
            EX_mem_OUT       <= ISS_mem_IN;
            EX_opA_OUT       <= src1Val;
            EX_opB_OUT       <= issImmSrc ? issImm[DATA_WIDTH-1:0] : src2Val;
            EX_storeData_OUT <= src2Val;
            EX_dest_OUT      <= issDest;
            EX_needDest_OUT  <= issNeedDest;
            EX_aluCtl_OUT    <= issAluCtl;
            EX_ctl_OUT       <= issCtl;
            EX_rob_OUT       <= issRob;
            EX_pc_OUT        <= issPc;
            EX_instr_OUT     <= issInstr;
         end
      end
   end

   // Debug-only count of packets that made it into the execute stage.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         rd_count <= '0;
      end else if (accept) begin
         rd_count <= rd_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_phys_reg_read.sv
// Self-checking bench for phys_reg_read: directed scenarios plus randomized traffic
// checked against an array-based model of the register file and execute packet.
module tb_phys_reg_read;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          FREEZE;
   logic          FLUSH_IN;
   logic          ISS_valid_IN;
   logic          ISS_mem_IN;
   logic [136:0]  ISS_data_IN;
   logic          WB0_valid_IN;
   logic [5:0]    WB0_reg_IN;
   logic [31:0]   WB0_data_IN;
   logic          WB1_valid_IN;
   logic [5:0]    WB1_reg_IN;
   logic [31:0]   WB1_data_IN;
   logic          EX_valid_OUT;
   logic          EX_mem_OUT;
   logic [31:0]   EX_opA_OUT;
   logic [31:0]   EX_opB_OUT;
   logic [31:0]   EX_storeData_OUT;
   logic [5:0]    EX_dest_OUT;
   logic          EX_needDest_OUT;
   logic [5:0]    EX_aluCtl_OUT;
   logic [5:0]    EX_ctl_OUT;
   logic [5:0]    EX_rob_OUT;
   logic [31:0]   EX_pc_OUT;
   logic [31:0]   EX_instr_OUT;

   int checks = 0;
   int errors = 0;

   phys_reg_read #(.DATA_WIDTH(32), .PREG_BITS(6), .ISS_WIDTH(137)) dut (
      .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH_IN(FLUSH_IN),
      .ISS_valid_IN(ISS_valid_IN), .ISS_mem_IN(ISS_mem_IN), .ISS_data_IN(ISS_data_IN),
      .WB0_valid_IN(WB0_valid_IN), .WB0_reg_IN(WB0_reg_IN), .WB0_data_IN(WB0_data_IN),
      .WB1_valid_IN(WB1_valid_IN), .WB1_reg_IN(WB1_reg_IN), .WB1_data_IN(WB1_data_IN),
      .EX_valid_OUT(EX_valid_OUT), .EX_mem_OUT(EX_mem_OUT), .EX_opA_OUT(EX_opA_OUT),
      .EX_opB_OUT(EX_opB_OUT), .EX_storeData_OUT(EX_storeData_OUT), .EX_dest_OUT(EX_dest_OUT),
      .EX_needDest_OUT(EX_needDest_OUT), .EX_aluCtl_OUT(EX_aluCtl_OUT), .EX_ctl_OUT(EX_ctl_OUT),
      .EX_rob_OUT(EX_rob_OUT), .EX_pc_OUT(EX_pc_OUT), .EX_instr_OUT(EX_instr_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        valid;
      logic        mem;
      logic [31:0] opA;
      logic [31:0] opB;
      logic [31:0] sd;
      logic [5:0]  dest;
      logic        needDest;
      logic [5:0]  alu;
      logic [5:0]  ctl;
      logic [5:0]  rob;
      logic [31:0] pc;
      logic [31:0] instr;
   } ex_t;

   logic [31:0] mRf [64];
   ex_t         mEx;
   logic [31:0] mCount;

   function automatic ex_t dutEx();
      return {EX_valid_OUT, EX_mem_OUT, EX_opA_OUT, EX_opB_OUT, EX_storeData_OUT, EX_dest_OUT,
              EX_needDest_OUT, EX_aluCtl_OUT, EX_ctl_OUT, EX_rob_OUT, EX_pc_OUT, EX_instr_OUT};
   endfunction

   // Value an instruction issued this cycle sees for register r.
   function automatic logic [31:0] mRead(input logic [5:0] r);
`ifdef PHYS_REG_READ_BYPASS_EN
      if (WB0_valid_IN && WB0_reg_IN == r) return WB0_data_IN;
      if (WB1_valid_IN && WB1_reg_IN == r) return WB1_data_IN;
`endif
      return mRf[r];
   endfunction

   function automatic logic [136:0] makePkt(input logic [5:0] s1, input logic [5:0] s2,
                                            input logic immSrc, input logic [31:0] imm);
      logic [159:0] t;
      logic [136:0] p;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      p = t[136:0];
      p[97]    = immSrc;
      p[88:83] = s2;
      p[81:76] = s1;
      p[75:44] = imm;
      return p;
   endfunction

   // Advance the model by the rules for the current inputs, then clock the DUT.
   task automatic tick();
      if (!RESET) begin
         for (int i = 0; i < 64; i++) mRf[i] = 32'h0;
         mEx    = '0;
         mCount = 32'h0;
      end else begin
         if (FLUSH_IN) begin
            mEx.valid = 1'b0;
         end else if (!FREEZE) begin
            if (ISS_valid_IN) begin
               mEx.valid    = 1'b1;
               mEx.mem      = ISS_mem_IN;
               mEx.opA      = mRead(ISS_data_IN[81:76]);
               mEx.sd       = mRead(ISS_data_IN[88:83]);
               mEx.opB      = ISS_data_IN[97] ? ISS_data_IN[75:44] : mEx.sd;
               mEx.dest     = ISS_data_IN[95:90];
               mEx.needDest = ISS_data_IN[96];
               mEx.alu      = ISS_data_IN[43:38];
               mEx.ctl      = ISS_data_IN[103:98];
               mEx.rob      = ISS_data_IN[37:32];
               mEx.pc       = ISS_data_IN[136:105];
               mEx.instr    = ISS_data_IN[31:0];
               mCount       = mCount + 32'd1;
            end else begin
               mEx.valid = 1'b0;
            end
         end
         if (WB1_valid_IN) mRf[WB1_reg_IN] = WB1_data_IN;
         if (WB0_valid_IN) mRf[WB0_reg_IN] = WB0_data_IN;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      RESET        = 1'b1;
      FREEZE       = 1'b0;
      FLUSH_IN     = 1'b0;
      ISS_valid_IN = 1'b0;
      WB0_valid_IN = 1'b0;
      WB1_valid_IN = 1'b0;
   endtask

   task automatic issue(input logic [136:0] pkt);
      ISS_valid_IN = 1'b1;
      ISS_mem_IN   = 1'($urandom_range(0, 1));
      ISS_data_IN  = pkt;
   endtask

   task automatic test_reset();
      idle();
      ISS_mem_IN  = 1'b0;
      ISS_data_IN = makePkt(6'd1, 6'd2, 1'b0, 32'h0);
      RESET        = 1'b0;
      FREEZE       = 1'b1;
      FLUSH_IN     = 1'b1;
      ISS_valid_IN = 1'b1;
      WB0_valid_IN = 1'b1; WB0_reg_IN = 6'd1; WB0_data_IN = 32'hFFFF_FFFF;
      WB1_valid_IN = 1'b1; WB1_reg_IN = 6'd2; WB1_data_IN = 32'h1111_2222;
      tick();
      tick();
      checks++;
      if (dutEx() !== ex_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0", dutEx());
      end
      checks++;
      if (dut.rd_count !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd_count got=%h want=0", dut.rd_count);
      end
      idle();
      issue(makePkt(6'd1, 6'd2, 1'b0, 32'h0));
      tick();
      $display("reset: read r1/r2 after reset opA=%h opB=%h", EX_opA_OUT, EX_opB_OUT);
      checks++;
      if (EX_opA_OUT !== 32'h0 || EX_opB_OUT !== 32'h0 || EX_valid_OUT !== 1'b1) begin
         errors++;
         $display("FAIL reset_read got opA=%h opB=%h valid=%b want 0/0/1", EX_opA_OUT, EX_opB_OUT, EX_valid_OUT);
      end
   endtask

   task automatic test_basic();
      idle();
      WB0_valid_IN = 1'b1; WB0_reg_IN = 6'd5; WB0_data_IN = 32'h0000_1234;
      tick();
      idle();
      issue(makePkt(6'd5, 6'd7, 1'b0, 32'hCAFE_0000));
      tick();
      $display("basic: src1=5 src2=7 opA=%h opB=%h valid=%b", EX_opA_OUT, EX_opB_OUT, EX_valid_OUT);
      checks++;
      if (EX_opA_OUT !== 32'h1234 || EX_opB_OUT !== 32'h0 || EX_valid_OUT !== 1'b1) begin
         errors++;
         $display("FAIL basic got opA=%h opB=%h valid=%b want 1234/0/1", EX_opA_OUT, EX_opB_OUT, EX_valid_OUT);
      end
      checks++;
      if (dutEx() !== mEx) begin
         errors++;
         $display("FAIL basic_packet got=%h want=%h", dutEx(), mEx);
      end
      idle();
      tick();
      $display("basic: bubble valid=%b opA=%h", EX_valid_OUT, EX_opA_OUT);
      checks++;
      if (EX_valid_OUT !== 1'b0 || EX_opA_OUT !== 32'h1234 || dutEx() !== mEx) begin
         errors++;
         $display("FAIL bubble_hold got=%h want=%h", dutEx(), mEx);
      end
   endtask

   task automatic test_immediate();
      idle();
      issue(makePkt(6'($urandom_range(0, 63)), 6'd5, 1'b1, 32'hFFFF_FFF0));
      tick();
      $display("immediate: opB=%h storeData=%h", EX_opB_OUT, EX_storeData_OUT);
      checks++;
      if (EX_opB_OUT !== 32'hFFFF_FFF0 || EX_storeData_OUT !== 32'h1234) begin
         errors++;
         $display("FAIL immediate got opB=%h sd=%h want fffffff0/1234", EX_opB_OUT, EX_storeData_OUT);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] want;
      idle();
      WB0_valid_IN = 1'b1; WB0_reg_IN = 6'd9; WB0_data_IN = 32'h55;
      tick();
      idle();
      WB1_valid_IN = 1'b1; WB1_reg_IN = 6'd9; WB1_data_IN = 32'hAA;
      issue(makePkt(6'd9, 6'd9, 1'b0, 32'h0));
      tick();
`ifdef PHYS_REG_READ_BYPASS_EN
      want = 32'hAA;
`else
      want = 32'h55;
`endif
      $display("bypass: same-cycle WB1 r9 opA=%h opB=%h", EX_opA_OUT, EX_opB_OUT);
      checks++;
      if (EX_opA_OUT !== want || EX_opB_OUT !== want || EX_storeData_OUT !== want) begin
         errors++;
         $display("FAIL bypass got opA=%h opB=%h sd=%h want %h", EX_opA_OUT, EX_opB_OUT, EX_storeData_OUT, want);
      end
      idle();
      issue(makePkt(6'd9, 6'd0, 1'b1, 32'h0));
      tick();
      checks++;
      if (EX_opA_OUT !== 32'hAA) begin
         errors++;
         $display("FAIL bypass_after got opA=%h want aa", EX_opA_OUT);
      end
   endtask

   task automatic test_conflict();
      idle();
      WB0_valid_IN = 1'b1; WB0_reg_IN = 6'd3; WB0_data_IN = 32'h1;
      WB1_valid_IN = 1'b1; WB1_reg_IN = 6'd3; WB1_data_IN = 32'h2;
      tick();
      idle();
      issue(makePkt(6'd3, 6'd3, 1'b0, 32'h0));
      tick();
      $display("conflict: r3 read opA=%h", EX_opA_OUT);
      checks++;
      if (EX_opA_OUT !== 32'h1 || EX_opB_OUT !== 32'h1) begin
         errors++;
         $display("FAIL conflict got opA=%h opB=%h want 1", EX_opA_OUT, EX_opB_OUT);
      end
   endtask

   task automatic test_reg0();
      idle();
      WB1_valid_IN = 1'b1; WB1_reg_IN = 6'd0; WB1_data_IN = 32'hDEAD_BEEF;
      tick();
      idle();
      issue(makePkt(6'd0, 6'd0, 1'b0, 32'h0));
      tick();
      $display("reg0: opA=%h", EX_opA_OUT);
      checks++;
      if (EX_opA_OUT !== 32'hDEAD_BEEF || EX_storeData_OUT !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL reg0 got opA=%h sd=%h want deadbeef", EX_opA_OUT, EX_storeData_OUT);
      end
   endtask

   task automatic test_hold_flush();
      ex_t snap;
      idle();
      issue(makePkt(6'd5, 6'd3, 1'b0, 32'h0));
      tick();
      snap = mEx;
      checks++;
      if (dutEx() !== snap || snap.valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_setup got=%h want=%h", dutEx(), snap);
      end
      for (int c = 0; c < 3; c++) begin
         idle();
         FREEZE = 1'b1;
         issue(makePkt(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom()));
         WB0_valid_IN = 1'b1; WB0_reg_IN = 6'd20; WB0_data_IN = 32'h2000 + 32'(c);
         tick();
         $display("hold: cycle %0d valid=%b pc=%h", c, EX_valid_OUT, EX_pc_OUT);
         checks++;
         if (dutEx() !== snap) begin
            errors++;
            $display("FAIL freeze_hold%0d got=%h want=%h", c, dutEx(), snap);
         end
      end
      idle();
      FREEZE = 1'b1; FLUSH_IN = 1'b1;
      issue(makePkt(6'd1, 6'd1, 1'b0, 32'h0));
      tick();
      snap.valid = 1'b0;
      $display("flush: with freeze valid=%b", EX_valid_OUT);
      checks++;
      if (dutEx() !== snap) begin
         errors++;
         $display("FAIL flush_freeze got=%h want=%h", dutEx(), snap);
      end
      idle();
      issue(makePkt(6'd20, 6'd1, 1'b0, 32'h0));
      tick();
      idle();
      FLUSH_IN = 1'b1;
      issue(makePkt(6'd1, 6'd1, 1'b0, 32'h0));
      tick();
      checks++;
      if (EX_valid_OUT !== 1'b0 || EX_opA_OUT !== 32'h2002) begin
         errors++;
         $display("FAIL flush_issue got valid=%b opA=%h want 0/2002", EX_valid_OUT, EX_opA_OUT);
      end
   endtask

   task automatic test_random();
      int valids = 0;
      for (int c = 0; c < 400; c++) begin
         RESET        = ($urandom_range(0, 99) != 0);
         FREEZE       = ($urandom_range(0, 3) == 0);
         FLUSH_IN     = ($urandom_range(0, 7) == 0);
         ISS_valid_IN = 1'($urandom_range(0, 1));
         ISS_mem_IN   = 1'($urandom_range(0, 1));
         ISS_data_IN  = makePkt(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                                1'($urandom_range(0, 1)), $urandom());
         WB0_valid_IN = 1'($urandom_range(0, 1));
         WB0_reg_IN   = 6'($urandom_range(0, 15));
         WB0_data_IN  = $urandom();
         WB1_valid_IN = 1'($urandom_range(0, 1));
         WB1_reg_IN   = 6'($urandom_range(0, 15));
         WB1_data_IN  = $urandom();
         tick();
         if (EX_valid_OUT) begin
            valids++;
            $display("random: cycle %0d pc=%h opA=%h opB=%h sd=%h", c, EX_pc_OUT, EX_opA_OUT, EX_opB_OUT, EX_storeData_OUT);
         end
         checks++;
         if (dutEx() !== mEx) begin
            errors++;
            $display("FAIL random_c%0d got=%h want=%h", c, dutEx(), mEx);
         end
      end
      checks++;
      if (dut.rd_count !== mCount) begin
         errors++;
         $display("FAIL rd_count got=%h want=%h", dut.rd_count, mCount);
      end
      $display("random: %0d valid packets observed", valids);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_immediate();
      test_bypass();
      test_conflict();
      test_reg0();
      test_hold_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
